// File: rtl/step_sequencer_param.sv
// step_sequencer_param: steps a registered state index through a programmable
// range [0..eff_last] in WRAP, ONESHOT, PINGPONG or DOWN mode. The block also
// provides preload, pause, a one-cycle terminal-count pulse (tc) and a
// saturating count of tc events.
module step_sequencer_param #(
  parameter int NUM_STATES = 38,
  parameter int W          = 9,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic [1:0]       mode,
  input  logic [W-1:0]     last_state,
  input  logic             load,
  input  logic [W-1:0]     load_value,
  output logic [W-1:0]     state,
  output logic             dir,
  output logic             tc,
  output logic             done,
  output logic [CNT_W-1:0] wrap_count
);

  localparam logic [1:0]       MODE_WRAP    = 2'b00;
  localparam logic [1:0]       MODE_ONESHOT = 2'b01;
  localparam logic [1:0]       MODE_PINGPNG = 2'b10;
  localparam logic [1:0]       MODE_DOWN    = 2'b11;
  localparam logic [W-1:0]     ZERO_W       = {W{1'b0}};
  localparam logic [W-1:0]     ONE_W        = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]     LAST_IDX     = W'(NUM_STATES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  // Reject parameter sets the index register cannot represent.
  if (NUM_STATES < 2 || NUM_STATES > 512) begin : g_bad_num_states
    $error("step_sequencer_param: NUM_STATES must be in 2..512");
  end
  if ((2 ** W) < NUM_STATES) begin : g_bad_width
    $error("step_sequencer_param: W too small for NUM_STATES");
  end

  logic [W-1:0]     state_r, state_nx_s;
  logic             dir_r, dir_nx_s;
  logic             tc_r, tc_nx_s;
  logic             done_r, done_nx_s;
  logic [CNT_W-1:0] wrap_cnt_r, wrap_cnt_nx_s;
  logic [W-1:0]     eff_last_s;

  // Clamp the programmed final index to the physical range.
  always_comb begin
    if (last_state <= LAST_IDX) begin
      eff_last_s = last_state;
    end else begin
      eff_last_s = LAST_IDX;
    end
  end

  // State register: rst dominates, otherwise take the computed next values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ZERO_W;
      dir_r      <= 1'b0;
      tc_r       <= 1'b0;
      done_r     <= 1'b0;
      wrap_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_nx_s;
      dir_r      <= dir_nx_s;
      tc_r       <= tc_nx_s;
      done_r     <= done_nx_s;
      wrap_cnt_r <= wrap_cnt_nx_s;
    end
  end

  // Next-state logic in priority order load > !start > pause > step.
  // Every +1/-1 sits behind a boundary test so the index never wraps.
  always_comb begin
    state_nx_s = state_r;
    dir_nx_s   = dir_r;
    done_nx_s  = done_r;
    tc_nx_s    = 1'b0;
    if (load) begin
      if (load_value <= eff_last_s) begin
        state_nx_s = load_value;
      end else begin
        state_nx_s = ZERO_W;
      end
      dir_nx_s  = (mode == MODE_DOWN);
      done_nx_s = 1'b0;
    end else if (!start) begin
      state_nx_s = ZERO_W;
      dir_nx_s   = 1'b0;
      done_nx_s  = 1'b0;
    end else if (pause) begin
      state_nx_s = state_r;
      dir_nx_s   = dir_r;
    end else if (state_r > eff_last_s) begin
      // Range shrank under the index: restart quietly from 0.
      state_nx_s = ZERO_W;
      dir_nx_s   = (mode == MODE_DOWN);
    end else begin
      case (mode)
        MODE_WRAP: begin
          dir_nx_s = 1'b0;
          if (state_r == eff_last_s) begin
            state_nx_s = ZERO_W;
            tc_nx_s    = 1'b1;
          end else begin
            state_nx_s = state_r + ONE_W;
          end
        end
        MODE_ONESHOT: begin
          dir_nx_s = 1'b0;
          if (state_r == eff_last_s) begin
            // Already at the end (mode entered late or degenerate range).
            state_nx_s = state_r;
            done_nx_s  = 1'b1;
          end else if ((state_r + ONE_W) == eff_last_s) begin
            // Arrival: done and tc become visible together with the end index.
            state_nx_s = state_r + ONE_W;
            done_nx_s  = 1'b1;
            tc_nx_s    = 1'b1;
          end else begin
            state_nx_s = state_r + ONE_W;
          end
        end
        MODE_PINGPNG: begin
          if (!dir_r) begin
            if (state_r == eff_last_s) begin
              tc_nx_s = 1'b1;
              if (eff_last_s == ZERO_W) begin
                state_nx_s = ZERO_W;
                dir_nx_s   = 1'b0;
              end else begin
                state_nx_s = eff_last_s - ONE_W;
                dir_nx_s   = 1'b1;
              end
            end else begin
              state_nx_s = state_r + ONE_W;
              dir_nx_s   = 1'b0;
            end
          end else begin
            if (state_r == ZERO_W) begin
              tc_nx_s  = 1'b1;
              dir_nx_s = 1'b0;
              if (eff_last_s == ZERO_W) begin
                state_nx_s = ZERO_W;
              end else begin
                state_nx_s = ONE_W;
              end
            end else begin
              state_nx_s = state_r - ONE_W;
              dir_nx_s   = 1'b1;
            end
          end
        end
        MODE_DOWN: begin
          dir_nx_s = 1'b1;
          if (state_r == ZERO_W) begin
            state_nx_s = eff_last_s;
            tc_nx_s    = 1'b1;
          end else begin
            state_nx_s = state_r - ONE_W;
          end
        end
        default: begin
          state_nx_s = state_r;
          dir_nx_s   = dir_r;
        end
      endcase
    end
  end

  // Saturating tc event counter; only the step path can raise tc.
  always_comb begin
    if (tc_nx_s && (wrap_cnt_r != CNT_MAX)) begin
      wrap_cnt_nx_s = wrap_cnt_r + CNT_ONE;
    end else begin
      wrap_cnt_nx_s = wrap_cnt_r;
    end
  end

  // Outputs come straight from registers so downstream decoders see no glitches.
  always_comb begin
    state      = state_r;
    dir        = dir_r;
    tc         = tc_r;
    done       = done_r;
    wrap_count = wrap_cnt_r;
  end

endmodule

// File: tb/tb_step_sequencer_param.sv
// Directed bench for step_sequencer_param: a vector table for the mode
// sequences plus hand-written runs for wrap, pause/reset and saturation.
module tb_step_sequencer_param;

  logic       clk = 1'b0;
  logic       rst, start, pause, load;
  logic [1:0] mode;
  logic [8:0] last_state, load_value;
  logic [8:0] state, state2;
  logic       dir, tc, done, dir2, tc2, done2;
  logic [7:0] wrap_count;
  logic [1:0] wrap_count2;

  int n_checks = 0;
  int n_fail   = 0;

  step_sequencer_param #(.NUM_STATES(38), .W(9), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .mode(mode),
    .last_state(last_state), .load(load), .load_value(load_value),
    .state(state), .dir(dir), .tc(tc), .done(done), .wrap_count(wrap_count)
  );

  step_sequencer_param #(.NUM_STATES(38), .W(9), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .mode(mode),
    .last_state(last_state), .load(load), .load_value(load_value),
    .state(state2), .dir(dir2), .tc(tc2), .done(done2), .wrap_count(wrap_count2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, start, pause;
    logic [1:0] mode;
    logic [8:0] last;
    logic       load;
    logic [8:0] lv;
    logic [8:0] e_state;
    logic       e_dir, e_tc, e_done;
    logic [7:0] e_wc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic [1:0] md, input logic [8:0] last,
                     input logic ld, input logic [8:0] lv, input logic [8:0] es,
                     input logic ed, input logic et, input logic edn, input logic [7:0] ew);
    vec_t v;
    v.rst = 1'b0; v.start = st; v.pause = 1'b0; v.mode = md; v.last = last;
    v.load = ld; v.lv = lv; v.e_state = es; v.e_dir = ed; v.e_tc = et;
    v.e_done = edn; v.e_wc = ew;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; load = 1'b1; load_value = 9'd5;
    mode = 2'b00; last_state = 9'd37;
    step();
    step();
    // rst wins over a simultaneous load
    check("reset.state", 32'(state), 32'd0);
    check("reset.dir", 32'(dir), 32'd0);
    check("reset.tc", 32'(tc), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.wc", 32'(wrap_count), 32'd0);

    // WRAP over 0..37 for 80 steps
    rst = 1'b0; load = 1'b0; start = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      step();
      check($sformatf("wrap%0d.state", n), 32'(state), 32'(n % 38));
      check($sformatf("wrap%0d.tc", n), 32'(tc), 32'((n % 38) == 0));
    end
    check("wrap.wc", 32'(wrap_count), 32'd2);

    // ONESHOT last=5 (state starts at 4, wc=2)
    add(0, 2'd1, 9'd5, 0, 9'd0,  9'd0, 0, 0, 0, 8'd2);
    add(1, 2'd1, 9'd5, 0, 9'd0,  9'd1, 0, 0, 0, 8'd2);
    add(1, 2'd1, 9'd5, 0, 9'd0,  9'd2, 0, 0, 0, 8'd2);
    add(1, 2'd1, 9'd5, 0, 9'd0,  9'd3, 0, 0, 0, 8'd2);
    add(1, 2'd1, 9'd5, 0, 9'd0,  9'd4, 0, 0, 0, 8'd2);
    add(1, 2'd1, 9'd5, 0, 9'd0,  9'd5, 0, 1, 1, 8'd3);
    add(1, 2'd1, 9'd5, 0, 9'd0,  9'd5, 0, 0, 1, 8'd3);
    add(1, 2'd1, 9'd5, 0, 9'd0,  9'd5, 0, 0, 1, 8'd3);
    add(0, 2'd1, 9'd5, 0, 9'd0,  9'd0, 0, 0, 0, 8'd3);
    // PINGPONG last=3
    add(1, 2'd2, 9'd3, 0, 9'd0,  9'd1, 0, 0, 0, 8'd3);
    add(1, 2'd2, 9'd3, 0, 9'd0,  9'd2, 0, 0, 0, 8'd3);
    add(1, 2'd2, 9'd3, 0, 9'd0,  9'd3, 0, 0, 0, 8'd3);
    add(1, 2'd2, 9'd3, 0, 9'd0,  9'd2, 1, 1, 0, 8'd4);
    add(1, 2'd2, 9'd3, 0, 9'd0,  9'd1, 1, 0, 0, 8'd4);
    add(1, 2'd2, 9'd3, 0, 9'd0,  9'd0, 1, 0, 0, 8'd4);
    add(1, 2'd2, 9'd3, 0, 9'd0,  9'd1, 0, 1, 0, 8'd5);
    add(1, 2'd2, 9'd3, 0, 9'd0,  9'd2, 0, 0, 0, 8'd5);
    add(1, 2'd2, 9'd3, 0, 9'd0,  9'd3, 0, 0, 0, 8'd5);
    add(0, 2'd2, 9'd3, 0, 9'd0,  9'd0, 0, 0, 0, 8'd5);
    // DOWN with last_state beyond range (clamped to 37), then loads
    add(1, 2'd3, 9'd500, 0, 9'd0,  9'd37, 1, 1, 0, 8'd6);
    add(1, 2'd3, 9'd500, 0, 9'd0,  9'd36, 1, 0, 0, 8'd6);
    add(1, 2'd3, 9'd500, 0, 9'd0,  9'd35, 1, 0, 0, 8'd6);
    add(1, 2'd3, 9'd500, 1, 9'd50, 9'd0,  1, 0, 0, 8'd6);
    add(1, 2'd3, 9'd500, 1, 9'd10, 9'd10, 1, 0, 0, 8'd6);
    add(1, 2'd3, 9'd500, 0, 9'd0,  9'd9,  1, 0, 0, 8'd6);
    add(0, 2'd3, 9'd500, 1, 9'd7,  9'd7,  1, 0, 0, 8'd6);
    add(0, 2'd3, 9'd500, 0, 9'd0,  9'd0,  0, 0, 0, 8'd6);
    // Out-of-range after last_state is lowered
    add(1, 2'd0, 9'd37, 1, 9'd10, 9'd10, 0, 0, 0, 8'd6);
    add(1, 2'd0, 9'd5,  0, 9'd0,  9'd0,  0, 0, 0, 8'd6);
    add(1, 2'd0, 9'd5,  0, 9'd0,  9'd1,  0, 0, 0, 8'd6);
    // Mode changes: DOWN -> PINGPONG turn at 0, PINGPONG -> ONESHOT at end
    add(1, 2'd3, 9'd5,  0, 9'd0,  9'd0,  1, 0, 0, 8'd6);
    add(1, 2'd2, 9'd5,  0, 9'd0,  9'd1,  0, 1, 0, 8'd7);
    add(1, 2'd2, 9'd5,  0, 9'd0,  9'd2,  0, 0, 0, 8'd7);
    add(1, 2'd1, 9'd2,  0, 9'd0,  9'd2,  0, 0, 1, 8'd7);
    add(0, 2'd1, 9'd2,  0, 9'd0,  9'd0,  0, 0, 0, 8'd7);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; start = vecs[i].start; pause = vecs[i].pause;
      mode = vecs[i].mode; last_state = vecs[i].last;
      load = vecs[i].load; load_value = vecs[i].lv;
      step();
      check($sformatf("v%0d.state", i), 32'(state), 32'(vecs[i].e_state));
      check($sformatf("v%0d.dir", i), 32'(dir), 32'(vecs[i].e_dir));
      check($sformatf("v%0d.tc", i), 32'(tc), 32'(vecs[i].e_tc));
      check($sformatf("v%0d.done", i), 32'(done), 32'(vecs[i].e_done));
      check($sformatf("v%0d.wc", i), 32'(wrap_count), 32'(vecs[i].e_wc));
    end

    // Pause at 12 for four cycles, resume to 20, then reset
    load = 1'b0; start = 1'b1; pause = 1'b0; mode = 2'b00; last_state = 9'd37;
    for (int n = 0; n < 12; n++) step();
    check("pre_pause.state", 32'(state), 32'd12);
    pause = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      check($sformatf("pause%0d.state", n), 32'(state), 32'd12);
      check($sformatf("pause%0d.tc", n), 32'(tc), 32'd0);
    end
    pause = 1'b0;
    for (int n = 0; n < 8; n++) step();
    check("resume.state", 32'(state), 32'd20);
    check("resume.wc", 32'(wrap_count), 32'd7);
    rst = 1'b1;
    step();
    check("rst_mid.state", 32'(state), 32'd0);
    check("rst_mid.wc", 32'(wrap_count), 32'd0);
    check("rst_mid.done", 32'(done), 32'd0);
    check("rst_mid.dir", 32'(dir), 32'd0);

    // Degenerate range: tc on every step; 2-bit counter saturates at 3
    rst = 1'b0; start = 1'b1; mode = 2'b00; last_state = 9'd0;
    for (int n = 1; n <= 5; n++) begin
      step();
      check($sformatf("deg%0d.state", n), 32'(state), 32'd0);
      check($sformatf("deg%0d.tc", n), 32'(tc), 32'd1);
      check($sformatf("deg%0d.wc", n), 32'(wrap_count), 32'(n));
      check($sformatf("sat%0d.wc", n), 32'(wrap_count2), 32'((n > 3) ? 3 : n));
    end
    mode = 2'b11;
    step();
    check("deg_down.tc", 32'(tc), 32'd1);
    check("deg_down.dir", 32'(dir), 32'd1);
    mode = 2'b10;
    step();
    check("deg_pp.state", 32'(state), 32'd0);
    check("deg_pp.tc", 32'(tc), 32'd1);
    check("deg_pp.dir", 32'(dir), 32'd0);
    mode = 2'b01;
    step();
    check("deg_os.state", 32'(state), 32'd0);
    check("deg_os.done", 32'(done), 32'd1);
    check("deg_os.wc_sat", 32'(wrap_count2), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
